// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage that feeds the instruction decoder.
//   Holds the fetch PC and issues word requests over a valid/ready channel.
//   It buffers in-order responses in a small FIFO and presents
//   {instr, instr_pc} to decode.
//   A redirect flushes the buffer and marks in-flight responses for discard.
// Optional build macro: IFU_ALIGN_FAULT_EN (adds fetch_fault; misaligned
//   redirect targets block fetch until an aligned redirect arrives).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req_valid/ready/addr       fetch request channel
//   imem_resp_valid/data            in-order response, no backpressure
//   redirect_valid/pc               flush and restart fetch at redirect_pc
//   instr_valid/ready, instr, instr_pc  decoder handshake and payload
//   fetch_fault                     (IFU_ALIGN_FAULT_EN only) misaligned target
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'hBFC00000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef IFU_ALIGN_FAULT_EN
    output logic        fetch_fault,
`endif
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   buf_data [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [31:0]   hold_instr;
    logic [31:0]   hold_pc;
    logic          blocked;

    logic          req_fire;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_word;

`ifdef IFU_ALIGN_FAULT_EN
    logic          fault_q;
    assign fetch_fault = fault_q;
    assign blocked     = fault_q;
`else
    // Low target bits are deliberately ignored: fetch is word-granular.
    logic unused_redirect_low;
    assign unused_redirect_low = &{1'b0, redirect_pc[1:0]};
    assign blocked = 1'b0;
`endif

    // Request gating, FIFO handshake and head/hold output selection.
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = fetch_pc;
        redirect_word  = {redirect_pc[31:2], 2'b00};
        // Reserving a FIFO slot per in-flight word means responses never stall.
        if (rst_n && !redirect_valid && !blocked &&
            ((outstanding + count) < CW'(FIFO_DEPTH))) begin
            imem_req_valid = 1'b1;
        end
        req_fire    = imem_req_valid && imem_req_ready;
        instr_valid = (count != '0);
        push        = imem_resp_valid && !redirect_valid && (drop == '0);
        pop         = instr_valid && instr_ready && !redirect_valid;
        instr       = hold_instr;
        instr_pc    = hold_pc;
        if (instr_valid) begin
            instr    = buf_data[rd_ptr];
            instr_pc = buf_pc[rd_ptr];
        end
    end

    // Buffer storage; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_resp_data;
            buf_pc[wr_ptr]   <= resp_pc;
        end
    end

    // PCs, FIFO pointers and in-flight bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            hold_instr  <= '0;
            hold_pc     <= '0;
`ifdef IFU_ALIGN_FAULT_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            // Output holds whatever was last presented while the FIFO is empty.
            hold_instr <= instr;
            hold_pc    <= instr_pc;
            if (redirect_valid) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= redirect_word;
                resp_pc  <= redirect_word;
                // Every word still in flight belongs to the old stream.
                outstanding <= outstanding - CW'(imem_resp_valid);
                drop        <= outstanding - CW'(imem_resp_valid);
`ifdef IFU_ALIGN_FAULT_EN
                fault_q <= (redirect_pc[1:0] != 2'b00);
`endif
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (imem_resp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                count       <= count + CW'(push) - CW'(pop);
                outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a behavioural memory answers each
// accepted fetch in order with addr^0x55; the reference model tracks the
// expected fetch PC and the queue of live (non-redirected) fetched words.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;
    localparam int DEPTH = 2;
    localparam logic [31:0] XOR_KEY = 32'h00000055;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef IFU_ALIGN_FAULT_EN
    logic        fetch_fault;
`endif

    instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
`ifdef IFU_ALIGN_FAULT_EN
        .fetch_fault     (fetch_fault),
`endif
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          pops     = 0;
    bit          tb_active = 1'b0;
    logic [31:0] m_pc;
    bit          m_fault  = 1'b0;
    logic [31:0] exp_q[$];
    mreq_t       mem_q[$];

    int          lat_min = 1, lat_max = 1;
    int          rdy_pct = 100, dec_pct = 100, redir_pct = 0;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard: everything here takes effect at the next rising edge.
    always @(negedge clk) begin
        if (tb_active) begin
`ifdef IFU_ALIGN_FAULT_EN
            check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
`endif
            if (redirect_valid) begin
                check("no_req_in_redirect", 32'(imem_req_valid), 32'd0);
                exp_q.delete();
                m_pc = redirect_pc & 32'hFFFFFFFC;
`ifdef IFU_ALIGN_FAULT_EN
                m_fault = (redirect_pc[1:0] != 2'b00);
`endif
            end else begin
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_instr actual_pc=%h expected=none", instr_pc);
                    end else begin
                        logic [31:0] e;
                        e = exp_q.pop_front();
                        check("instr_pc", instr_pc, e);
                        check("instr", instr, e ^ XOR_KEY);
                        pops++;
                    end
                end
                if (m_fault) begin
                    check("req_blocked_by_fault", 32'(imem_req_valid), 32'd0);
                end
                if (imem_req_valid && imem_req_ready) begin
                    mreq_t m;
                    check("req_addr", imem_req_addr, m_pc);
                    check("live_words_cap", 32'(exp_q.size() < DEPTH), 32'd1);
                    check("inflight_cap",
                          32'((mem_q.size() + int'(imem_resp_valid)) < DEPTH), 32'd1);
                    exp_q.push_back(m_pc);
                    m.addr = m_pc;
                    m.due  = cyc + int'($urandom_range(lat_max, lat_min));
                    mem_q.push_back(m);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // One cycle of stimulus: memory response, handshakes, optional redirect.
    task automatic cycle();
        @(posedge clk);
        #1;
        imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
        instr_ready    = ($urandom_range(99, 0) < dec_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            mreq_t m;
            m = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = m.addr ^ XOR_KEY;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else if ($urandom_range(99, 0) < redir_pct) begin
            redirect_valid = 1'b1;
            case ($urandom_range(2, 0))
                0:       redirect_pc = 32'hFFFFFFF8;
                1:       redirect_pc = $urandom & 32'hFFFFFFFC;
                default: redirect_pc = $urandom;
            endcase
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        force_pc    = pc;
        force_redir = 1'b1;
        cycle();
    endtask

    initial begin
        int p0;
        rst_n           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        instr_ready     = 1'b1;
        force_pc        = '0;
        m_pc            = RESET_PC;
        repeat (3) @(posedge clk);
        #2;
        check("reset_req_valid", 32'(imem_req_valid), 32'd0);
        check("reset_instr_valid", 32'(instr_valid), 32'd0);
        check("reset_instr", instr, 32'd0);
        check("reset_instr_pc", instr_pc, 32'd0);
        check("reset_req_addr", imem_req_addr, RESET_PC);
`ifdef IFU_ALIGN_FAULT_EN
        check("reset_fetch_fault", 32'(fetch_fault), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        tb_active = 1'b1;

        // Streaming with a 1-cycle memory.
        p0 = pops;
        run(40);
        check("progress_stream", 32'(pops > p0 + 20), 32'd1);

        // Decoder stall: buffer fills and requests stop with nothing in flight.
        dec_pct = 0;
        run(12);
        #1;
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_instr_valid", 32'(instr_valid), 32'd1);
        check("stall_mem_idle", 32'(mem_q.size()), 32'd0);
        dec_pct = 100;
        p0 = pops;
        run(20);
        check("progress_after_stall", 32'(pops > p0 + 5), 32'd1);

        // 3-cycle memory; redirect with words in flight.
        lat_min = 3;
        lat_max = 3;
        run(10);
        redirect_to(32'h00400000);
        p0 = pops;
        run(30);
        check("progress_after_redirect", 32'(pops > p0), 32'd1);

        // Steady-state redirect (response and pop coincide) to the wrap point.
        lat_min = 1;
        lat_max = 1;
        run(10);
        redirect_to(32'hFFFFFFF8);
        p0 = pops;
        run(20);
        check("progress_after_wrap", 32'(pops > p0 + 5), 32'd1);

        // Randomised traffic.
        lat_max   = 4;
        rdy_pct   = 70;
        dec_pct   = 60;
        redir_pct = 5;
        run(2000);
        redir_pct = 0;
        redirect_to(32'h00001000);
        p0 = pops;
        run(40);
        check("progress_random", 32'(pops > p0), 32'd1);

`ifdef IFU_ALIGN_FAULT_EN
        rdy_pct = 100;
        dec_pct = 100;
        redirect_to(32'h00400002);
        run(5);
        #1;
        check("fault_set", 32'(fetch_fault), 32'd1);
        check("fault_blocks_req", 32'(imem_req_valid), 32'd0);
        redirect_to(32'h00400010);
        p0 = pops;
        run(20);
        check("fault_cleared", 32'(fetch_fault), 32'd0);
        check("progress_after_fault", 32'(pops > p0), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
